// File: rtl/quantum_scheduler.sv
// ---------------------------------------------------------------------------
// quantum_scheduler
//   Round-robin time-slice scheduler for a small multi-process core. It tracks
//   which process slots are ready, counts user instructions retired in the
//   current slice, and hands control to the OS through save/load handshakes
//   when a process ends or (optionally) its quantum expires.
//
//   Build option: define QUANTUM_PREEMPT_EN to enable quantum preemption.
//   Without it the scheduler is cooperative: quantum_cnt still counts
//   (saturating at 31), and only end_proc leaves RUN.
//
// Ports
//   i_clock          rising-edge system clock
//   i_reset          synchronous active-high reset
//   i_instr_retired  one-cycle pulse per completed user instruction
//   i_end_proc       running process executed its halt
//   i_proc_create    mark slot i_create_pid ready
//   i_create_pid     slot to create
//   i_ctx_done       OS finished the requested save/load
//   i_pc_curr        PC proposed by the user datapath
//   o_enable_so      OS mode active (every state except RUN)
//   o_pc_new         PC to fetch: SO_PC in OS mode, else i_pc_curr
//   o_cur_pid        running process
//   o_next_pid       process selected for load
//   o_save_req       ask OS to save context of o_cur_pid
//   o_load_req       ask OS to restore context of o_next_pid
//   o_quantum_cnt    instructions retired in the current slice
// ---------------------------------------------------------------------------
module quantum_scheduler #(
    parameter int          NUM_PROC = 8,
    parameter int          QUANTUM  = 20,
    parameter logic [31:0] SO_PC    = 32'd3
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_instr_retired,
    input  logic        i_end_proc,
    input  logic        i_proc_create,
    input  logic [2:0]  i_create_pid,
    input  logic        i_ctx_done,
    input  logic [31:0] i_pc_curr,
    output logic        o_enable_so,
    output logic [31:0] o_pc_new,
    output logic [2:0]  o_cur_pid,
    output logic [2:0]  o_next_pid,
    output logic        o_save_req,
    output logic        o_load_req,
    output logic [4:0]  o_quantum_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_LOAD
    } state_t;

    localparam logic [4:0] QLAST = 5'(QUANTUM - 1);
    localparam logic [4:0] QSAT  = 5'd31;

    state_t              r_state, w_state_nxt;
    logic [NUM_PROC-1:0] r_ready, w_ready_nxt;
    logic [2:0]          r_cur_pid, w_cur_pid_nxt;
    logic [2:0]          r_next_pid, w_next_pid_nxt;
    logic [4:0]          r_qcnt, w_qcnt_nxt;
    logic                w_found;
    logic [2:0]          w_pick;

    // Round-robin scan starting just after the running slot and ending on
    // it, so a process that is still ready is only re-picked when nobody
    // else is waiting.
    always_comb begin
        logic [2:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_pick  = r_cur_pid;
        for (int k = 1; k <= NUM_PROC; k++) begin
            v_idx = 3'((int'(r_cur_pid) + k) % NUM_PROC);
            if (!w_found && r_ready[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ready_nxt    = r_ready;
        w_cur_pid_nxt  = r_cur_pid;
        w_next_pid_nxt = r_next_pid;
        w_qcnt_nxt     = r_qcnt;
        case (r_state)
            S_IDLE: begin
                if (|r_ready) w_state_nxt = S_SELECT;
            end
            S_RUN: begin
                // A halting process leaves without a save; this takes
                // priority over a quantum expiry in the same cycle.
                if (i_end_proc) begin
                    w_ready_nxt[r_cur_pid] = 1'b0;
                    w_qcnt_nxt             = '0;
                    w_state_nxt            = S_SELECT;
                end else if (i_instr_retired) begin
`ifdef QUANTUM_PREEMPT_EN
                    if (r_qcnt == QLAST) begin
                        w_qcnt_nxt  = '0;
                        w_state_nxt = S_SAVE;
                    end else begin
                        w_qcnt_nxt = r_qcnt + 5'd1;
                    end
`else
                    if (r_qcnt != QSAT) w_qcnt_nxt = r_qcnt + 5'd1;
`endif
                end
            end
            S_SAVE: begin
                if (i_ctx_done) w_state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (w_found) begin
                    w_next_pid_nxt = w_pick;
                    w_state_nxt    = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (i_ctx_done) begin
                    w_cur_pid_nxt = r_next_pid;
                    w_state_nxt   = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Applied last so a create wins over an end_proc clearing the
        // same slot.
        if (i_proc_create) w_ready_nxt[i_create_pid] = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_ready    <= '0;
            r_cur_pid  <= '0;
            r_next_pid <= '0;
            r_qcnt     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= w_ready_nxt;
            r_cur_pid  <= w_cur_pid_nxt;
            r_next_pid <= w_next_pid_nxt;
            r_qcnt     <= w_qcnt_nxt;
        end
    end

    assign o_enable_so   = (r_state != S_RUN);
    assign o_save_req    = (r_state == S_SAVE);
    assign o_load_req    = (r_state == S_LOAD);
    assign o_pc_new      = o_enable_so ? SO_PC : i_pc_curr;
    assign o_cur_pid     = r_cur_pid;
    assign o_next_pid    = r_next_pid;
    assign o_quantum_cnt = r_qcnt;

    logic w_unused;
    assign w_unused = ^QSAT ^ ^QLAST;

endmodule

// File: doc/quantum_scheduler.md
QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

Interface
REQ-001 Parameter NUM_PROC, default 8, number of process slots (PID width 3 bits).
REQ-002 Parameter QUANTUM, default 20, user instructions per time slice, legal range 1..31.
REQ-003 Parameter SO_PC, default 32'd3, OS context-switch entry address.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-006 instr_retired  input  1  one-cycle pulse per completed user instruction.
REQ-007 end_proc  input  1  current process has executed its halt.
REQ-008 proc_create  input  1  mark slot create_pid ready.
REQ-009 create_pid  input  3  slot to create.
REQ-010 ctx_done  input  1  OS finished the requested save/load.
REQ-011 pc_curr  input  32  PC proposed by user datapath.
REQ-012 enable_so  output  1  OS mode active.
REQ-013 pc_new  output  32  PC to fetch.
REQ-014 cur_pid  output  3  running process.
REQ-015 next_pid  output  3  process selected for load.
REQ-016 save_req  output  1  request OS to save context of cur_pid.
REQ-017 load_req  output  1  request OS to restore context of next_pid.
REQ-018 quantum_cnt  output  5  instructions retired in current slice.

Function
REQ-019 FSM states SHALL be IDLE, RUN, SAVE, SELECT, LOAD; all outputs except pc_new are registered or decoded from registered state.
REQ-020 IDLE: any ready bit set -> SELECT next cycle; else stay.
REQ-021 RUN: each instr_retired increments quantum_cnt; instr_retired with quantum_cnt==QUANTUM-1 -> SAVE, quantum_cnt cleared.
REQ-022 RUN: end_proc -> SELECT (no save), clears ready bit of cur_pid, quantum_cnt cleared; end_proc wins over simultaneous quantum expiry.
REQ-023 SAVE: save_req=1 until ctx_done sampled high, then -> SELECT.
REQ-024 SELECT (exactly one cycle): scan cur_pid+1, cur_pid+2, ... wrapping modulo NUM_PROC, ending at cur_pid; first ready slot latched into next_pid -> LOAD; none ready -> IDLE.
REQ-025 LOAD: load_req=1 until ctx_done sampled high, then cur_pid<=next_pid, -> RUN.
REQ-026 ctx_done outside SAVE/LOAD SHALL be ignored.
REQ-027 enable_so=1 in every state except RUN.
REQ-028 pc_new SHALL be SO_PC when enable_so=1, else pc_curr (combinational).
REQ-029 proc_create sets ready[create_pid] in any state; already-set bit unchanged; simultaneous create and end_proc on same slot leaves it set.
REQ-030 instr_retired and end_proc outside RUN SHALL be ignored.

Reset
REQ-031 On reset: state IDLE, ready=0, cur_pid=0, next_pid=0, quantum_cnt=0, save_req=0, load_req=0, enable_so=1, pc_new=SO_PC.
REQ-032 Reset mid-SAVE/LOAD SHALL drop requests next cycle; proc_create in the reset cycle is discarded.

Configuration
REQ-033 Macro QUANTUM_PREEMPT_EN defined: preemption per REQ-021.
REQ-034 Macro QUANTUM_PREEMPT_EN undefined: cooperative; quantum_cnt still counts, saturating at 31; only end_proc leaves RUN.

Verification
REQ-035 Reset; create pid 2 -> SELECT, LOAD with next_pid=2; ctx_done -> RUN, cur_pid=2, enable_so=0, pc_new=pc_curr.
REQ-036 Pids 1,2 ready, running 1; 20 instr_retired pulses -> SAVE on 20th, save_req=1, then SELECT picks 2, pc_new=3 throughout.
REQ-037 Running 7 of {0,7} ready; end_proc -> ready[7]=0, SELECT wraps to 0, no save_req asserted.
REQ-038 Sole process ends -> SELECT finds none -> IDLE, enable_so=1; later create pid 5 -> resumes with next_pid=5.
REQ-039 end_proc and 20th instr_retired same cycle -> SELECT path, save_req never asserted; reset during LOAD -> load_req=0, IDLE, ready=0.
